// File: rtl/ball_cmd_sched.sv
// Arrow-key command scheduler: edge-detects arrow keys into a FIFO, issues
// one direction per handshake with a hold gap; spacebar toggles pause.
// Ports: frame_clk, Reset (async, active-high), key[7:0], cmd_ready ->
//        cmd_valid, cmd_dir[1:0], paused, fifo_count[3:0], overflow.
// Option: BALL_REVERSE_REJECT_EN drops presses opposite to the last direction.
module ball_cmd_sched #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HOLD_FRAMES = 8,
    parameter logic [7:0] KEY_PAUSE   = 8'h2C
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] key,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    output logic       paused,
    output logic [3:0] fifo_count,
    output logic       overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES - 1);
    localparam logic [3:0]    FULL_CNT  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, PAUSED} state_t;

    state_t        state, state_d;
    logic [7:0]    key_q;
    logic          pause_pend, pause_pend_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    head;
    logic          is_arrow;
    logic [1:0]    arrow_dir;
    logic          press, pause_edge, pop, full, reject;
    logic          arrow_ok, push, drop, flush;
    logic          cmd_valid_d, paused_d;
    logic [1:0]    cmd_dir_d;

    assign head = mem[rd_ptr];

    always_comb begin
        is_arrow  = 1'b1;
        arrow_dir = 2'd0;
        unique case (key)
            8'h52:   arrow_dir = 2'd0;
            8'h51:   arrow_dir = 2'd1;
            8'h50:   arrow_dir = 2'd2;
            8'h4F:   arrow_dir = 2'd3;
            default: is_arrow  = 1'b0;
        endcase
    end

    assign press      = is_arrow && (key != key_q);
    assign pause_edge = (key == KEY_PAUSE) && (key_q != KEY_PAUSE);
    assign pop        = cmd_valid && cmd_ready;
    assign full       = (fifo_count == FULL_CNT);

`ifdef BALL_REVERSE_REJECT_EN
    logic [1:0] last_iss;
    logic       last_iss_v;
    logic [1:0] last_dir;
    logic       last_ok;

    // Compare against the queue tail, or the last issued command when empty.
    always_comb begin
        if (fifo_count != 4'd0) begin
            last_dir = mem[wr_ptr - PW'(1)];
            last_ok  = 1'b1;
        end else begin
            last_dir = last_iss;
            last_ok  = last_iss_v;
        end
    end

    // up/down and left/right differ only in bit 0.
    assign reject = last_ok && (arrow_dir == (last_dir ^ 2'b01));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            last_iss   <= 2'd0;
            last_iss_v <= 1'b0;
        end else if (pop) begin
            last_iss   <= head;
            last_iss_v <= 1'b1;
        end
    end
`else
    assign reject = 1'b0;
`endif

    assign arrow_ok = press && (state != PAUSED) && !reject;
    assign push     = arrow_ok && (!full || pop);
    assign drop     = arrow_ok && full && !pop;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            key_q      <= 8'h00;
            pause_pend <= 1'b0;
            hold_cnt   <= '0;
            cmd_valid  <= 1'b0;
            cmd_dir    <= 2'd0;
            paused     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_d;
            key_q      <= key;
            pause_pend <= pause_pend_d;
            hold_cnt   <= hold_d;
            cmd_valid  <= cmd_valid_d;
            cmd_dir    <= cmd_dir_d;
            paused     <= paused_d;
            overflow   <= overflow | drop;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (pause_pend)
                    state_d = PAUSED;
                else if (fifo_count != 4'd0)
                    state_d = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready)
                    state_d = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0)
                    state_d = pause_pend ? PAUSED : IDLE;
            end
            PAUSED: begin
                if (pause_edge)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid_d  = cmd_valid;
        cmd_dir_d    = cmd_dir;
        paused_d     = paused;
        hold_d       = hold_cnt;
        flush        = 1'b0;
        pause_pend_d = pause_pend | (pause_edge && (state != PAUSED));
        unique case (state)
            IDLE: begin
                if (!pause_pend && (fifo_count != 4'd0)) begin
                    cmd_valid_d = 1'b1;
                    cmd_dir_d   = head;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    hold_d      = HOLD_INIT;
                end
            end
            HOLD: begin
                if (hold_cnt != '0)
                    hold_d = hold_cnt - HW'(1);
            end
            PAUSED: begin
                if (pause_edge)
                    paused_d = 1'b0;
            end
            default: ;
        endcase
        // Entering pause empties the queue and consumes the request.
        if ((state_d == PAUSED) && (state != PAUSED)) begin
            flush        = 1'b1;
            paused_d     = 1'b1;
            pause_pend_d = 1'b0;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 4'd0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 4'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + 4'(push) - 4'(pop);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (push)
            mem[wr_ptr] <= arrow_dir;
    end

endmodule

// File: tb/tb_ball_cmd_sched.sv
// Testbench for ball_cmd_sched: directed vector table, hand sequences for
// hold spacing / pause / async reset, and randomized run against a model.
module tb_ball_cmd_sched;

    localparam int D = 4;
    localparam int H = 8;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] key = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       paused;
    logic [3:0] fifo_count;
    logic       overflow;

    ball_cmd_sched dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .key       (key),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .paused    (paused),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         rst;
        logic [7:0] k;
        logic       rdy;
        logic       ev;
        logic [1:0] ed;
        logic [3:0] ec;
        logic       ep;
        logic       eo;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [1:0] d,
                           input logic [3:0] c, input logic p, input logic o);
        chk({nm, ".valid"}, 32'(cmd_valid), 32'(v));
        chk({nm, ".dir"}, 32'(cmd_dir), 32'(d));
        chk({nm, ".count"}, 32'(fifo_count), 32'(c));
        chk({nm, ".paused"}, 32'(paused), 32'(p));
        chk({nm, ".ovf"}, 32'(overflow), 32'(o));
    endtask

    task automatic step();
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        key = 8'h00;
        cmd_ready = 1'b0;
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic drive(input logic [7:0] k);
        key = k;
        step();
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        while (!cmd_valid && n < 40) begin
            step();
            n++;
        end
        if (!cmd_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: cmd_valid timeout got 0 expected 1", nm);
        end
    endtask

    // Reference model: queue of directions plus issue/pause eligibility times.
    int         q[$];
    bit         mv, mp, mpend, movf;
    int         md;
    logic [7:0] mkq;
    int         cyc, pause_ok, issue_ok;
    int         last_iss;
    bit         last_v;

    function void model_reset();
        q.delete();
        mv = 0; mp = 0; mpend = 0; movf = 0; md = 0;
        mkq = 8'h00; cyc = 0; pause_ok = 0; issue_ok = 0;
        last_iss = 0; last_v = 0;
    endfunction

    function void model_step(input logic [7:0] k, input logic r);
        bit is_arr, pr, pe, hs, enter, rej;
        int dir, old_size;
        is_arr = 1; dir = 0;
        case (k)
            8'h52: dir = 0;
            8'h51: dir = 1;
            8'h50: dir = 2;
            8'h4F: dir = 3;
            default: is_arr = 0;
        endcase
        pr = is_arr && (k != mkq);
        pe = (k == 8'h2C) && (mkq != 8'h2C);
        cyc++;
        hs = mv && r;
        old_size = q.size();
        rej = 0;
`ifdef BALL_REVERSE_REJECT_EN
        if (old_size > 0) rej = (dir == (q[$] ^ 1));
        else rej = last_v && (dir == (last_iss ^ 1));
`endif
        enter = !mv && !mp && mpend && (cyc >= pause_ok);
        if (hs) begin
            last_iss = q.pop_front();
            last_v = 1;
            mv = 0;
            pause_ok = cyc + H;
            issue_ok = cyc + H + 1;
        end else if (!mv && !mp && !mpend && cyc >= issue_ok && old_size > 0) begin
            mv = 1;
            md = q[0];
        end
        if (pr && !mp && !rej) begin
            if (q.size() < D) q.push_back(dir);
            else movf = 1;
        end
        if (mp) begin
            if (pe) mp = 0;
        end else if (pe) begin
            mpend = 1;
        end
        if (enter) begin
            q.delete();
            mp = 1;
            mpend = 0;
        end
        mkq = k;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] pool [7];
        pool[0] = 8'h00; pool[1] = 8'h52; pool[2] = 8'h51; pool[3] = 8'h50;
        pool[4] = 8'h4F; pool[5] = 8'h2C; pool[6] = 8'h04;

        // Table: held key gives one command, then fill to overflow.
        tbl.push_back('{1'b1, 8'h52, 1'b1, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h52, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0});
        for (int i = 0; i < 18; i++)
            tbl.push_back('{1'b0, 8'h52, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'h52, 1'b0, 1'b0, 2'd0, 4'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h51, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h50, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h4F, 1'b0, 1'b1, 2'd0, 4'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h52, 1'b0, 1'b1, 2'd0, 4'd4, 1'b0, 1'b1});

        do_reset();
        chk_out("reset", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            key = tbl[i].k;
            cmd_ready = tbl[i].rdy;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed,
                    tbl[i].ec, tbl[i].ep, tbl[i].eo);
        end

        // Drain the full queue: 9-cycle gap from handshake to next valid.
        key = 8'h00;
        cmd_ready = 1'b1;
        step();
        chk_out("drain0", 1'b0, 2'd0, 4'd3, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            wait_valid("drain", n);
            chk($sformatf("gap%0d", i), n, H + 1);
            chk($sformatf("ddir%0d", i), 32'(cmd_dir), i);
            step();
            chk($sformatf("dcnt%0d", i), 32'(fifo_count), 3 - i);
        end
        repeat (12) step();
        chk_out("drained", 1'b0, 2'd3, 4'd0, 1'b0, 1'b1);

        // Push and pop on the same edge while full, across pointer wrap.
        do_reset();
        drive(8'h52); drive(8'h00); drive(8'h51); drive(8'h00);
        drive(8'h50); drive(8'h00); drive(8'h4F); drive(8'h00);
        chk_out("full", 1'b1, 2'd0, 4'd4, 1'b0, 1'b0);
        key = 8'h52;
        cmd_ready = 1'b1;
        step();
        chk_out("pushpop", 1'b0, 2'd0, 4'd4, 1'b0, 1'b0);
        key = 8'h00;
        for (int i = 1; i < 5; i++) begin
            wait_valid("wrap", n);
            chk($sformatf("wdir%0d", i), 32'(cmd_dir), i % 4);
            step();
        end
        chk("wrapcnt", 32'(fifo_count), 0);

        // Pause during ISSUE: command held, pause after hold, presses ignored.
        do_reset();
        drive(8'h52); drive(8'h00); drive(8'h51); drive(8'h2C); drive(8'h00);
        chk_out("pissue", 1'b1, 2'd0, 4'd2, 1'b0, 1'b0);
        cmd_ready = 1'b1;
        step();
        chk_out("phs", 1'b0, 2'd0, 4'd1, 1'b0, 1'b0);
        cmd_ready = 1'b0;
        n = 0;
        while (!paused && n < 40) begin
            step();
            n++;
        end
        chk("pgap", n, H);
        chk_out("pentry", 1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        drive(8'h50); drive(8'h00); drive(8'h51);
        chk_out("pign", 1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        drive(8'h2C);
        chk_out("pexit", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        drive(8'h00); drive(8'h00); drive(8'h00);
        chk_out("pidle", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset while a command is outstanding.
        do_reset();
        drive(8'h52); drive(8'h00); drive(8'h51); drive(8'h00); drive(8'h50);
        chk_out("prerst", 1'b1, 2'd0, 4'd3, 1'b0, 1'b0);
        #2 Reset = 1'b1;
        #1 chk_out("asyncrst", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        @(negedge frame_clk);
        Reset = 1'b0;

`ifdef BALL_REVERSE_REJECT_EN
        do_reset();
        cmd_ready = 1'b1;
        drive(8'h4F); drive(8'h4F);
        chk("rvdir", 32'(cmd_dir), 3);
        drive(8'h00); drive(8'h50);
        chk_out("rvrej", 1'b0, 2'd3, 4'd0, 1'b0, 1'b0);
        drive(8'h00); drive(8'h52);
        chk("rvcnt", 32'(fifo_count), 1);
        wait_valid("rv", n);
        chk("rvup", 32'(cmd_dir), 0);
`endif

        // Randomized run against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) >= 65) begin
                int idx;
                idx = $urandom_range(0, 6);
                if (idx == 5 && $urandom_range(0, 3) != 0) idx = 0;
                key = pool[idx];
            end
            cmd_ready = ($urandom_range(0, 99) < 35);
            @(posedge frame_clk);
            model_step(key, cmd_ready);
            @(negedge frame_clk);
            chk_out($sformatf("rnd%0d", i), mv, 2'(md), 4'(q.size()), mp, movf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
